// File: rtl/divider_seq_16x8_if.sv
// -----------------------------------------------------------------------------
// divider_seq_16x8_if
// Request/result bundle for the sequential 16/8 divider.
//   start        request strobe (sampled only when the divider can accept)
//   P[15:0]      dividend, latched on accept
//   B[7:0]       divisor, latched on accept
//   Q[7:0]       quotient, registered
//   R[7:0]       remainder, registered
//   busy         operation in flight
//   done         result valid
//   div_by_zero  error flag, valid with done
//   overflow     error flag (quotient would not fit 8 bits), valid with done
// master: requester side, slave: divider side.
// -----------------------------------------------------------------------------
interface divider_seq_16x8_if;
    logic        start;
    logic [15:0] P;
    logic [7:0]  B;
    logic [7:0]  Q;
    logic [7:0]  R;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output start, P, B,
        input  Q, R, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, P, B,
        output Q, R, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/divider_seq_16x8.sv
// -----------------------------------------------------------------------------
// divider_seq_16x8
// Sequential restoring divider: 16-bit dividend / 8-bit divisor giving an
// 8-bit quotient and 8-bit remainder, one quotient bit per clock (8 cycles).
// Divide-by-zero and quotient-overflow are detected at accept time and
// answered in a single cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   divider_seq_16x8_if.slave (start/P/B in, Q/R/busy/done/flags out)
//
// Build option:
//   DIV_DONE_HOLD_EN  when defined, DONE is held (done stays high, busy low)
//                     until the next start, which is accepted straight from
//                     DONE. When undefined, DONE lasts one cycle and start
//                     during DONE is ignored.
// -----------------------------------------------------------------------------
module divider_seq_16x8 (
    input  logic                  clk,
    input  logic                  rst,
    divider_seq_16x8_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef DIV_DONE_HOLD_EN
    localparam logic BUSY_IN_DONE = 1'b0;
`else
    localparam logic BUSY_IN_DONE = 1'b1;
`endif

    state_t      state_reg;
    logic [7:0]  p_reg;        // remaining low dividend bits, MSB next
    logic [7:0]  b_reg;        // latched divisor
    logic [7:0]  rem_reg;      // partial remainder, always < divisor
    logic [6:0]  q_work_reg;   // quotient bits collected so far
    logic [2:0]  cnt_reg;      // iteration index 0..7
    logic [7:0]  q_reg;
    logic [7:0]  r_reg;
    logic        dz_reg;
    logic        ov_reg;
    logic        done_reg;
    logic        busy_reg;

    logic        accept;
    logic [8:0]  rem_shift;    // 9-bit partial remainder after the shift
    logic [7:0]  rem_diff;
    logic        ge;
    logic [7:0]  rem_next;

`ifdef DIV_DONE_HOLD_EN
    assign accept = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
`else
    assign accept = bus.start && (state_reg == IDLE);
`endif

    // Because rem_reg < B, the shifted value is < 2*B, so after a successful
    // subtract the result fits in 8 bits and modulo-256 subtraction is exact.
    assign rem_shift = {rem_reg, p_reg[7]};
    assign ge        = (rem_shift >= {1'b0, b_reg});
    assign rem_diff  = rem_shift[7:0] - b_reg;
    assign rem_next  = ge ? rem_diff : rem_shift[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            p_reg      <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            q_work_reg <= '0;
            cnt_reg    <= '0;
            q_reg      <= '0;
            r_reg      <= '0;
            dz_reg     <= 1'b0;
            ov_reg     <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else if (accept) begin
            p_reg      <= bus.P[7:0];
            b_reg      <= bus.B;
            cnt_reg    <= '0;
            q_work_reg <= '0;
            // Zero divisor is checked first so it wins over overflow.
            if (bus.B == 8'h00) begin
                state_reg <= DONE;
                q_reg     <= 8'hFF;
                r_reg     <= bus.P[7:0];
                dz_reg    <= 1'b1;
                ov_reg    <= 1'b0;
                done_reg  <= 1'b1;
                busy_reg  <= BUSY_IN_DONE;
            end else if (bus.P[15:8] >= bus.B) begin
                // Quotient would need more than 8 bits.
                state_reg <= DONE;
                q_reg     <= 8'hFF;
                r_reg     <= 8'h00;
                dz_reg    <= 1'b0;
                ov_reg    <= 1'b1;
                done_reg  <= 1'b1;
                busy_reg  <= BUSY_IN_DONE;
            end else begin
                state_reg <= CALC;
                rem_reg   <= bus.P[15:8];
                dz_reg    <= 1'b0;
                ov_reg    <= 1'b0;
                done_reg  <= 1'b0;
                busy_reg  <= 1'b1;
            end
        end else begin
            case (state_reg)
                CALC: begin
                    rem_reg    <= rem_next;
                    q_work_reg <= {q_work_reg[5:0], ge};
                    p_reg      <= {p_reg[6:0], 1'b0};
                    cnt_reg    <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        state_reg <= DONE;
                        q_reg     <= {q_work_reg, ge};
                        r_reg     <= rem_next;
                        done_reg  <= 1'b1;
                        busy_reg  <= BUSY_IN_DONE;
                    end
                end
                DONE: begin
`ifndef DIV_DONE_HOLD_EN
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
`endif
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q           = q_reg;
    assign bus.R           = r_reg;
    assign bus.div_by_zero = dz_reg;
    assign bus.overflow    = ov_reg;
    assign bus.done        = done_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: doc/divider_seq_16x8.md
DIVIDER_SEQ_16X8 -- requirements
Module: divider_seq_16x8

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only when accepted (see REQ-012).
REQ-005 P  input  16  dividend; latched on accept.
REQ-006 B  input  8  divisor; latched on accept.
REQ-007 Q  output  8  quotient, registered.
REQ-008 R  output  8  remainder, registered.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 done  output  1  result-valid indication.
REQ-011 div_by_zero, overflow  output  1 each  error flags, registered, valid with done.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE; start is accepted only in IDLE (and in DONE when DIV_DONE_HOLD_EN is defined); start in CALC is ignored.
REQ-013 On accept, P and B SHALL be latched into internal working registers; later input changes have no effect on the operation.
REQ-014 On accept with B==0: next state DONE; div_by_zero=1, overflow=0, Q=8'hFF, R=P[7:0].
REQ-015 On accept with B!=0 and P[15:8]>=B: next state DONE; overflow=1, div_by_zero=0, Q=8'hFF, R=8'h00.
REQ-016 Otherwise: next state CALC; 9-bit partial remainder initialised to P[15:8]; iteration counter cleared; both flags cleared.
REQ-017 Each CALC cycle (restoring division, MSB first) SHALL shift the next dividend bit, P[7] down to P[0], into the partial remainder, and compare it with B.
REQ-018 Per iteration: if the result is >=B, subtract B and set the quotient bit to 1; otherwise restore and set the bit to 0.
REQ-019 CALC SHALL run exactly 8 cycles; on the 8th edge the state becomes DONE and Q=floor(P/B) and R=P mod B are loaded.
REQ-020 Latency: done=1 in the cycle after edge 8 following the accept edge (normal path) and in the cycle after the accept edge (error path).
REQ-021 done SHALL be high only in DONE (done = state==DONE); busy SHALL be high in CALC, and also in DONE when DIV_DONE_HOLD_EN is not defined.
REQ-022 Q, R and the flags SHALL hold their last values during IDLE and CALC, and change only on transition into DONE.
REQ-023 B==0 takes priority over the overflow check.

Reset
REQ-024 While rst=1: state=IDLE; Q=0, R=0, done=0, busy=0, div_by_zero=0, overflow=0; all internal registers cleared.
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start after rst deasserts is accepted normally.

Configuration
REQ-026 Macro DIV_DONE_HOLD_EN defined: DONE is held and done stays high until the next accepted start; start in DONE is accepted exactly as in IDLE; busy=0 in DONE.
REQ-027 DIV_DONE_HOLD_EN undefined: DONE lasts one cycle (done is a one-cycle pulse), then IDLE unconditionally; start during DONE is ignored.

Verification
REQ-028 P=16'hFE01, B=8'hFF, start pulse -> done 8 cycles after accept, Q=8'hFF, R=8'h00, flags 0; busy high for the CALC cycles.
REQ-029 P=16'h03E8, B=8'h07 -> Q=8'h8E, R=8'h06; inputs changed to random values during CALC do not alter the result.
REQ-030 P=16'h1234, B=8'h00 -> done 1 cycle after accept, div_by_zero=1, overflow=0, Q=8'hFF, R=8'h34.
REQ-031 P=16'h0700, B=8'h07 -> done 1 cycle after accept, overflow=1, Q=8'hFF, R=8'h00; P=16'h06FF, B=8'h07 -> Q=8'hFF, R=8'h06, no overflow.
REQ-032 Start re-pulsed with new operands in CALC -> ignored. rst asserted on the 4th CALC cycle -> all outputs 0, no done; the next start runs cleanly.
REQ-033 Run both builds: with DIV_DONE_HOLD_EN, done stays high until the next start, and back-to-back start from DONE is accepted; without it, done is exactly 1 cycle.
